// File: rtl/vt_sram_access_sequencer.sv
// vt_sram_access_sequencer: arbitrates translator enable against SRAM readback with break-before-make settle guards.
//   CLK, RST        clock; synchronous active-high reset
//   VT_REQ          level request to enable the voltage translators
//   RD_REQ          level request for an SRAM read, held until RD_GNT is seen
//   RD_DONE         one-cycle pulse ending the current read grant
//   VT_EN           registered translator enable
//   VT_READY        translators enabled and settled
//   RD_GNT          read permitted; translators off and settled
//   BUSY            high in either settle state
//   RD_TIMEOUT      sticky flag for a forced grant release
//   STATE           current state encoding for debug
module vt_sram_access_sequencer #(
    parameter int SETTLE_ON_CYC  = 8,
    parameter int SETTLE_OFF_CYC = 8,
    parameter int RD_TIMEOUT_CYC = 1024,
    parameter int CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VT_REQ,
    input  logic       RD_REQ,
    input  logic       RD_DONE,
    output logic       VT_EN,
    output logic       VT_READY,
    output logic       RD_GNT,
    output logic       BUSY,
    output logic       RD_TIMEOUT,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_ON_SETTLE  = 3'd1,
        S_ON         = 3'd2,
        S_OFF_SETTLE = 3'd3,
        S_RD         = 3'd4
    } state_t;

    // Terminal counter values: the counter restarts at 0 on every state entry,
    // so matching PARAM-1 gives a dwell of exactly PARAM cycles.
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(SETTLE_ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(SETTLE_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             vt_en_q, vt_ready_q, rd_gnt_q, busy_q, rd_timeout_q;
    logic             timeout_hit;

    // A read request or a dropped enable request aborts the translators at once.
    always_comb begin
        state_d = S_OFF;
        case (state_q)
            S_OFF:        state_d = RD_REQ ? S_RD : VT_REQ ? S_ON_SETTLE : S_OFF;
            S_ON_SETTLE:  state_d = (!VT_REQ || RD_REQ) ? S_OFF_SETTLE : (cnt_q == ON_LAST) ? S_ON : S_ON_SETTLE;
            S_ON:         state_d = (!VT_REQ || RD_REQ) ? S_OFF_SETTLE : S_ON;
            S_OFF_SETTLE: state_d = (cnt_q != OFF_LAST) ? S_OFF_SETTLE : RD_REQ ? S_RD : VT_REQ ? S_ON_SETTLE : S_OFF;
            S_RD:         state_d = (RD_DONE || cnt_q == RD_LAST) ? S_OFF : S_RD;
            default:      state_d = S_OFF;
        endcase
    end

    // RD_DONE on the terminal cycle counts as a normal completion.
    assign timeout_hit = (state_q == S_RD) && !RD_DONE && (cnt_q == RD_LAST);

    // Outputs are registered from the next state so they align with STATE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            vt_en_q      <= 1'b0;
            vt_ready_q   <= 1'b0;
            rd_gnt_q     <= 1'b0;
            busy_q       <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            vt_en_q      <= state_d inside {S_ON_SETTLE, S_ON};
            vt_ready_q   <= state_d == S_ON;
            rd_gnt_q     <= state_d == S_RD;
            busy_q       <= state_d inside {S_ON_SETTLE, S_OFF_SETTLE};
            rd_timeout_q <= rd_timeout_q | timeout_hit;
        end
    end

    assign VT_EN      = vt_en_q;
    assign VT_READY   = vt_ready_q;
    assign RD_GNT     = rd_gnt_q;
    assign BUSY       = busy_q;
    assign RD_TIMEOUT = rd_timeout_q;
    assign STATE      = state_q;
endmodule

// File: tb/tb_vt_sram_access_sequencer.sv
// tb_vt_sram_access_sequencer: directed and random stimulus against a dwell-countdown reference model.
module tb_vt_sram_access_sequencer;
    localparam int SON = 8, SOFF = 8, TO = 16;

    logic       CLK = 1'b0;
    logic       RST, VT_REQ, RD_REQ, RD_DONE;
    logic       VT_EN, VT_READY, RD_GNT, BUSY, RD_TIMEOUT;
    logic [2:0] STATE;

    int n_chk = 0, n_pass = 0, cyc = 0, fall_cyc = -1000, n = 0;
    int m_mode = 0, m_left = 0;
    bit m_to = 0;
    logic prev_en = 1'b0, prev_gnt = 1'b0;

    vt_sram_access_sequencer #(
        .SETTLE_ON_CYC(SON), .SETTLE_OFF_CYC(SOFF), .RD_TIMEOUT_CYC(TO), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .VT_REQ(VT_REQ), .RD_REQ(RD_REQ), .RD_DONE(RD_DONE),
        .VT_EN(VT_EN), .VT_READY(VT_READY), .RD_GNT(RD_GNT), .BUSY(BUSY),
        .RD_TIMEOUT(RD_TIMEOUT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Model: mode 0 idle, 1 warming, 2 ready, 3 cooling, 4 reading; m_left counts remaining dwell.
    task automatic enter(input int m);
        m_mode = m;
        m_left = (m == 1) ? SON : (m == 3) ? SOFF : (m == 4) ? TO : 0;
    endtask

    task automatic model_tick();
        if (RST) begin
            enter(0);
            m_to = 0;
        end else begin
            case (m_mode)
                0: if (RD_REQ) enter(4); else if (VT_REQ) enter(1);
                1: begin
                    m_left--;
                    if (!VT_REQ || RD_REQ) enter(3); else if (m_left == 0) enter(2);
                end
                2: if (!VT_REQ || RD_REQ) enter(3);
                3: begin
                    m_left--;
                    if (m_left == 0) enter(RD_REQ ? 4 : VT_REQ ? 1 : 0);
                end
                default: begin
                    m_left--;
                    if (RD_DONE) enter(0);
                    else if (m_left == 0) begin
                        enter(0);
                        m_to = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        bit was_rst;
        was_rst = RST;
        model_tick();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        chk("state", STATE, m_mode);
        chk("vt_en", VT_EN, (m_mode == 1 || m_mode == 2) ? 1 : 0);
        chk("vt_ready", VT_READY, (m_mode == 2) ? 1 : 0);
        chk("rd_gnt", RD_GNT, (m_mode == 4) ? 1 : 0);
        chk("busy", BUSY, (m_mode == 1 || m_mode == 3) ? 1 : 0);
        chk("rd_timeout", RD_TIMEOUT, m_to);
        chk("mutex", VT_EN & RD_GNT, 0);
        if (was_rst) fall_cyc = -1000;
        else if (prev_en && !VT_EN) fall_cyc = cyc;
        if (!prev_gnt && RD_GNT) chk("break_before_make", (cyc - fall_cyc >= SOFF) ? 1 : 0, 1);
        prev_en = VT_EN;
        prev_gnt = RD_GNT;
    endtask

    initial begin
        RST = 1; VT_REQ = 1; RD_REQ = 1; RD_DONE = 0;
        repeat (3) step();
        chk("reset_en", VT_EN, 0);
        chk("reset_gnt", RD_GNT, 0);
        RST = 0; VT_REQ = 0; RD_REQ = 0;
        step();
        chk("idle_state", STATE, 0);

        VT_REQ = 1;
        step();
        chk("en_cycle1", VT_EN, 1);
        repeat (7) step();
        chk("busy_cycle8", BUSY, 1);
        chk("not_ready_cycle8", VT_READY, 0);
        step();
        chk("ready_cycle9", VT_READY, 1);
        chk("busy_done", BUSY, 0);
        VT_REQ = 0;
        step();
        chk("disable_en", VT_EN, 0);
        repeat (7) step();
        chk("off_settle_busy", BUSY, 1);
        step();
        chk("back_off", STATE, 0);

        VT_REQ = 1;
        repeat (9) step();
        chk("on_ready", VT_READY, 1);
        RD_REQ = 1;
        step();
        chk("preempt_en_off", VT_EN, 0);
        n = 0;
        while (!RD_GNT && n < 64) begin step(); n++; end
        chk("gnt_after_settle", n, SOFF);
        RD_REQ = 0;
        repeat (5) step();
        RD_DONE = 1;
        step();
        RD_DONE = 0;
        chk("gnt_drop_after_done", RD_GNT, 0);
        step();
        chk("reenable_after_read", VT_EN, 1);

        VT_REQ = 0;
        n = 0;
        while (STATE != 0 && n < 64) begin step(); n++; end
        chk("reach_off", STATE, 0);
        VT_REQ = 1; RD_REQ = 1;
        step();
        chk("simul_gnt", RD_GNT, 1);
        chk("simul_en", VT_EN, 0);
        RD_REQ = 0;
        repeat (2) step();
        chk("simul_en_held", VT_EN, 0);
        RD_DONE = 1;
        step();
        RD_DONE = 0;
        chk("simul_gnt_drop", RD_GNT, 0);
        step();
        chk("simul_then_en", VT_EN, 1);

        VT_REQ = 0; RD_REQ = 1;
        n = 0;
        while (!RD_GNT && n < 64) begin step(); n++; end
        chk("to_gnt", RD_GNT, 1);
        RD_REQ = 0;
        n = 0;
        while (RD_GNT && n < 64) begin step(); n++; end
        chk("timeout_len", n, TO);
        chk("timeout_flag", RD_TIMEOUT, 1);
        repeat (5) step();
        chk("timeout_sticky", RD_TIMEOUT, 1);

        VT_REQ = 1;
        repeat (3) step();
        VT_REQ = 0;
        step();
        chk("abort_state", STATE, 3);
        n = 0;
        while (STATE == 3 && n < 64) begin n++; step(); end
        chk("abort_full_settle", n, SOFF);

        RD_REQ = 1;
        n = 0;
        while (!RD_GNT && n < 64) begin step(); n++; end
        RD_REQ = 0;
        repeat (2) step();
        chk("pre_reset_gnt", RD_GNT, 1);
        RST = 1;
        step();
        RST = 0;
        chk("reset_mid_read_gnt", RD_GNT, 0);
        chk("reset_clears_timeout", RD_TIMEOUT, 0);

        repeat (3000) begin
            RST = ($urandom_range(199) == 0);
            if ($urandom_range(9) == 0) VT_REQ = ~VT_REQ;
            if (RD_GNT) RD_REQ = 0;
            else if (!RD_REQ && $urandom_range(29) == 0) RD_REQ = 1;
            RD_DONE = ($urandom_range(7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vt_sram_access_sequencer.md
Name: vt_sram_access_sequencer

Overview:
Sequences shared use of the ASIC interface between the voltage translators and SRAM readback. The translators must never be enabled while SRAM is being read. This block sits between the tester command logic and the translator enable flop. It arbitrates translator-enable requests against SRAM read requests and enforces break-before-make guard intervals with programmable settle counts.

Parameters:
SETTLE_ON_CYC, 8, cycles from VT_EN rising to VT_READY asserting (translator power-up settle); legal range 1..2^CNT_W-1
SETTLE_OFF_CYC, 8, cycles from VT_EN falling to a read grant or re-enable being permitted (translator tri-state settle); legal range 1..2^CNT_W-1
RD_TIMEOUT_CYC, 1024, maximum cycles RD_GNT stays high before a forced release
CNT_W, 16, width of the shared guard/timeout counter

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
VT_REQ  in  1  level; high = translators wanted enabled
RD_REQ  in  1  level; high = SRAM read wanted; held until RD_GNT seen
RD_DONE  in  1  single-cycle pulse from reader; ends the current grant
VT_EN  out  1  registered translator enable
VT_READY  out  1  translators enabled and settled
RD_GNT  out  1  SRAM read permitted; translators guaranteed off and settled
BUSY  out  1  high in any settle state
RD_TIMEOUT  out  1  sticky; set on forced grant release, cleared only by RST
STATE  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered. Reset values: VT_EN=0, VT_READY=0, RD_GNT=0, BUSY=0, RD_TIMEOUT=0, STATE=OFF. The counter resets to 0.
- RST asserted in any state forces OFF in the next cycle, with VT_EN=0 in that same edge. Reset also abandons an in-flight grant.
- State OFF (0):
  - RD_REQ=1 → RD (RD_GNT=1 next cycle). RD_REQ has priority over VT_REQ when both are high.
  - Else VT_REQ=1 → ON_SETTLE, VT_EN=1 next cycle.
  - Otherwise stay in OFF.
- State ON_SETTLE (1): BUSY=1, VT_EN=1, counter counts up.
  - After SETTLE_ON_CYC cycles in the state → ON.
  - If VT_REQ drops or RD_REQ rises mid-settle → OFF_SETTLE immediately with VT_EN=0. No partial settle credit is kept.
- State ON (2): VT_EN=1, VT_READY=1.
  - VT_REQ=0 or RD_REQ=1 → OFF_SETTLE. VT_EN and VT_READY go to 0 on the same edge.
  - A read request always preempts the translators.
- State OFF_SETTLE (3): BUSY=1, VT_EN=0.
  - Must run the full SETTLE_OFF_CYC cycles even if requests change.
  - Then RD_REQ=1 → RD. Else VT_REQ=1 → ON_SETTLE. Else → OFF.
- State RD (4): RD_GNT=1, VT_EN=0, counter counts up.
  - RD_DONE=1 → OFF with RD_GNT=0 next cycle. No off-settle is needed because the translators are already off.
  - If the counter reaches RD_TIMEOUT_CYC without RD_DONE → OFF, RD_GNT=0, RD_TIMEOUT=1.
  - VT_REQ is ignored while in RD.
- RD_DONE outside RD is ignored.
- The counter clears on every state entry. Comparisons use counter == PARAM-1 at the terminal cycle, so dwell time equals PARAM exactly.
- Invariant: VT_EN and RD_GNT are never both 1 in any cycle.
- Invariant: RD_GNT never rises within SETTLE_OFF_CYC cycles of VT_EN falling.
- Unused STATE encodings 5–7 → OFF.

Test Plan:
- Reset/idle:
  - Stimulus: hold RST 3 cycles with VT_REQ=1, RD_REQ=1, then release and hold both low.
  - Required: all outputs 0 during reset; STATE=0 afterwards.
- Enable path:
  - Stimulus: VT_REQ=1 from cycle 0.
  - Required: VT_EN=1 at cycle 1; BUSY for 8 cycles; VT_READY=1 at cycle 9. VT_REQ=0 then gives VT_EN=0 next cycle, BUSY for 8 cycles, then OFF.
- Read preemption:
  - Stimulus: in ON, pulse RD_REQ high; pulse RD_DONE 5 cycles after RD_GNT rises.
  - Required: VT_EN=0 next cycle; RD_GNT=1 exactly 8 cycles later; RD_GNT=0 the cycle after RD_DONE.
  - Then, with VT_REQ still 1: VT_EN=1 the cycle after that.
- Simultaneous requests:
  - Stimulus: VT_REQ=1 and RD_REQ=1 in OFF.
  - Required: RD granted first with VT_EN staying 0; after RD_DONE, translator enable proceeds.
- Timeout:
  - Stimulus: RD granted, RD_DONE never pulsed, RD_TIMEOUT_CYC=16.
  - Required: RD_GNT drops after 16 cycles; RD_TIMEOUT=1 and stays 1 until RST.
- Abort mid-settle and reset mid-read:
  - Stimulus: drop VT_REQ at cycle 3 of ON_SETTLE.
  - Required: immediate OFF_SETTLE, full 8 cycles.
  - Stimulus: assert RST during RD.
  - Required: RD_GNT=0 next cycle.
  - Throughout: the mutual-exclusion assertion holds for all runs.
